// File: rtl/rv_pkg.sv
// Shared defaults for the register file and its scoreboard.
// Also provides the address-width derivation used by both modules.
package rv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // Smallest width w with 2**w >= n; NREGS is a power of two, so this is log2.
    function automatic int addr_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write flags for the architectural registers plus a registered
// population count of those flags.
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;
    logic             set_ok;
    logic             clr_ok;

    // The count tracks flag transitions instead of recounting every cycle;
    // an issue and a writeback to the same register leave the flag set.
    always_comb begin
        set_ok  = issue_valid && (issue_rd != '0) && !flush;
        clr_ok  = we && (rd_addr != '0) && !flush
                  && !(set_ok && (issue_rd == rd_addr));
        busy_d  = busy_q;
        count_d = count_q;
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            if (clr_ok && busy_q[rd_addr]) begin
                busy_d[rd_addr] = 1'b0;
                count_d         = count_d - CNT_ONE;
            end
            if (set_ok && !busy_q[issue_rd]) begin
                busy_d[issue_rd] = 1'b1;
                count_d          = count_d + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with optional write-to-read forwarding and a
// pending-write scoreboard; register 0 is hard-wired to zero.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                we,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic [AW:0]         busy_count
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] sb_busy;

    // Every entry is cleared asynchronously, so storage stays in flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (rd_addr != '0)) begin
            regs_q[rd_addr] <= wdata;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .we          (we),
        .rd_addr     (rd_addr),
        .flush       (flush),
        .busy        (sb_busy),
        .busy_count  (busy_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          hit;

            assign addr = rs_addr[gi*AW +: AW];
            // Forwarding is suppressed in reset so outputs show the cleared state.
            assign hit  = (BYPASS != 0) && rst_n && we
                          && (rd_addr == addr) && (addr != '0);

            assign rs_data[gi*XLEN +: XLEN] = hit ? wdata
                                            : ((addr == '0) ? '0 : regs_q[addr]);
            assign rs_busy[gi] = hit ? 1'b0 : sb_busy[addr];
        end
    endgenerate

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count (power of two, >= 2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have port clk, input, 1 bit, meaning single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning asynchronous, active-low reset.
REQ-007 SHALL have port rs_addr, input, NRD*AW bits, meaning read addresses; port k is bits [k*AW +: AW].
REQ-008 SHALL have port rs_data, output, NRD*XLEN bits, meaning read data per port.
REQ-009 SHALL have port rs_busy, output, NRD bits, meaning per-port pending-write flag for the addressed register.
REQ-010 SHALL have port we, input, 1 bit, meaning writeback enable.
REQ-011 SHALL have port rd_addr, input, AW bits, meaning writeback address.
REQ-012 SHALL have port wdata, input, XLEN bits, meaning writeback data.
REQ-013 SHALL have port issue_valid, input, 1 bit, meaning an instruction targeting issue_rd is issued this cycle.
REQ-014 SHALL have port issue_rd, input, AW bits, meaning destination register of the issued instruction.
REQ-015 SHALL have port flush, input, 1 bit, meaning clear all pending flags (pipeline flush).
REQ-016 SHALL have port busy_count, output, AW+1 bits, meaning number of registers currently pending.

Function
REQ-017 SHALL perform reads combinationally: rs_data[k] = reg[rs_addr[k]], zero latency.
REQ-018 SHALL force register 0 to read as zero and never be written, never be marked pending.
REQ-019 SHALL write wdata into reg[rd_addr] at the clock edge when we=1 and rd_addr != 0.
REQ-020 SHALL, when BYPASS=1 and we=1 and rd_addr=rs_addr[k]!=0, drive rs_data[k]=wdata and rs_busy[k]=0 in the same cycle.
REQ-021 SHALL, when BYPASS=0, return the pre-write register value and the registered busy flag.
REQ-022 SHALL set busy[issue_rd] at the edge when issue_valid=1 and issue_rd!=0.
REQ-023 SHALL clear busy[rd_addr] at the edge when we=1 and rd_addr!=0.
REQ-024 SHALL, on simultaneous issue and writeback to the same register, leave busy set (issue wins).
REQ-025 SHALL, when flush=1, clear all busy flags at the edge; a same-cycle issue_valid is ignored; a same-cycle write still updates data.
REQ-026 SHALL keep busy_count equal to the population count of busy flags, updated with the flags (register, not combinational popcount of next state).
REQ-027 SHALL allow multiple read ports to address the same register, each returning identical data.
REQ-028 SHALL treat re-issue to an already-busy register as a no-op on the flag and count.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear all registers to 0, all busy flags to 0, and busy_count to 0.
REQ-030 SHALL, when reset asserts mid-operation, discard any in-flight write or issue in that cycle; outputs follow cleared state immediately.
REQ-031 SHALL resume normal updates on the first rising clk edge after rst_n deasserts.

Structure
REQ-032 SHALL place XLEN/NREGS defaults and the AW derivation function in a shared package rv_pkg.
REQ-033 SHALL implement the pending-flag array and busy_count as one sub-module, reg_scoreboard; storage and read muxing stay in the top.

Verification
REQ-034 SHALL cover: reset, then read all registers on both ports -> every rs_data=0, rs_busy=0, busy_count=0.
REQ-035 SHALL cover: we=1, rd_addr=5, wdata=0xDEADBEEF, rs_addr port0=5 same cycle -> rs_data0=0xDEADBEEF (BYPASS=1), previous value (BYPASS=0); next cycle both 0xDEADBEEF.
REQ-036 SHALL cover: write 0x12345678 to reg 0 -> reads of reg 0 return 0; issue_rd=0 -> busy_count stays 0.
REQ-037 SHALL cover: issue regs 3,7,9 on consecutive cycles -> busy_count 1,2,3; writeback reg 7 -> busy_count=2, rs_busy for 7 =0.
REQ-038 SHALL cover: same-cycle issue_rd=4 and writeback rd_addr=4 with busy[4]=1 -> busy[4]=1 after edge, data updated; then flush=1 with issue_rd=6 -> busy_count=0.
REQ-039 SHALL cover: rst_n pulsed low between clock edges with busy_count=3 and data loaded -> outputs zero immediately, before next edge.
